line_serializer: RTL and testbench
==================================

// Module: line_serializer
// PURPOSE
//  Parametrised cache-line -> memory-word serializer; successor to the fixed 256b/32b shifter.
//  Sits between cache controller (writeback/evict path) and main-memory port.
//  Loads one LINE_W line per handshake and emits BEATS words over a valid/ready stream.
//  Adds: out_last flag, beat index, abort, one-cycle done pulse and optional critical-word-first.
// PARAMETERS
//  LINE_W     256  line width in bits; must be an integer multiple of WORD_W
//  WORD_W     32   beat width in bits; BEATS = LINE_W/WORD_W, must be >= 2
//  DESCENDING 0    0: beat order is word 0,1,..,BEATS-1; 1: word BEATS-1 down to 0
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            async active-low reset
//  in_valid     in   1            line available from cache
//  in_ready     out  1            serializer idle; line accepted when in_valid&&in_ready
//  in_line      in   LINE_W       line data; word k = in_line[k*WORD_W +: WORD_W]
//  in_start     in   $clog2(BEATS) first beat index (used only with CWF_EN)
//  abort        in   1            synchronous cancel of the line in flight
//  out_valid    out  1            beat valid
//  out_ready    in   1            memory accepts beat
//  out_data     out  WORD_W       beat data
//  out_idx      out  $clog2(BEATS) word index of current beat within the line
//  out_last     out  1            current beat is the final beat of the line
//  done         out  1            one-cycle pulse, cycle after final beat accepted
// BEHAVIOUR
//  Reset is async, active-low: state=IDLE, line_reg=0, beat_idx=0, sent_cnt=0, done=0;
//   outputs: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_data=0. Line in flight is discarded; no done.
//  FSM: IDLE -> SEND on in_valid&&in_ready (capture in_line, beat_idx=start, sent_cnt=0).
//       SEND -> IDLE on final beat handshake or abort. No other states.
//  in_ready = (state==IDLE); out_valid = (state==SEND). Load->first out_valid latency 1 cycle.
//  out_data = line_reg word[beat_idx], muxed from registers only (no comb path from inputs).
//  out_idx = beat_idx; out_last = out_valid && (sent_cnt==BEATS-1).
//  Beat handshake (out_valid&&out_ready): sent_cnt++, beat_idx steps +1 (or -1 if DESCENDING)
//   modulo BEATS, wrapping BEATS-1 -> 0 (0 -> BEATS-1 descending).
//  out_valid held with stable out_data/out_idx until out_ready; out_ready stalls indefinitely.
//  Final handshake: state->IDLE, done=1 next cycle only. Back-to-back lines have one idle
//   cycle between last beat and next load (in_ready rises the cycle after final beat).
//  abort in SEND with no final handshake: ->IDLE next cycle, no done, remaining beats dropped.
//  abort coincident with final handshake: line completes, done pulses (transfer already occurred).
//  abort in IDLE: ignored; in_valid in SEND: ignored (in_ready=0), line not captured.
//  Counters sized $clog2(BEATS); sent_cnt never exceeds BEATS-1.
// CONFIGURATION
//  LINE_SER_CWF_EN defined: critical-word-first; start beat = in_start sampled at load,
//   order wraps modulo BEATS (e.g. start 5, BEATS 8: 5,6,7,0,1,2,3,4). out_last by sent_cnt.
//  LINE_SER_CWF_EN undefined: in_start ignored; start = 0 (BEATS-1 when DESCENDING).
// STRUCTURE
//  serializer_pkg: ser_state_e {IDLE, SEND}; default LINE_W/WORD_W localparams.
//  One sub-module: wrap_counter (parametrised mod-N up/down counter with load, enable)
//   used for beat_idx; sent_cnt is a plain up-counter in the top.
// TESTING
//  1 Defaults, in_line word k = 32'hA000_000k, out_ready=1 -> beats A..0 .. A..7 on 8 cycles,
//    out_last on beat 7, done 1 cycle after, in_ready high the following cycle.
//  2 out_ready toggled 1/0 each cycle -> 16 cycles of out_valid, data held stable while stalled,
//    exactly 8 handshakes, single done pulse.
//  3 CWF_EN, in_start=5 -> out_idx 5,6,7,0,1,2,3,4, out_last with idx 4, done after.
//  4 abort after 3 beats -> out_valid drops next cycle, no done; new line then sends all 8.
//  5 abort with final handshake -> done=1; rst_n low mid-line -> out_valid=0, in_ready=1 at once, no done.
//  6 LINE_W=512, WORD_W=64, DESCENDING=1 -> beats word 7..0 of 64b, out_last on word 0.

Source files
------------

// File: rtl/line_serializer_pkg.sv
// Shared types and default geometry for the cache-line serializer.
package serializer_pkg;
   typedef enum logic {IDLE, SEND} ser_state_e;
   localparam int unsigned DEF_LINE_W = 256;
   localparam int unsigned DEF_WORD_W = 32;
endpackage

// File: rtl/line_serializer_wrap_counter.sv
// Mod-N up/down counter with synchronous load and count enable.
module wrap_counter #(
   parameter int unsigned N    = 8,
   parameter bit          DOWN = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 en,
   input  logic [$clog2(N)-1:0] load_val,
   output logic [$clog2(N)-1:0] count
);
   localparam int unsigned W = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         if (DOWN) count <= (count == '0) ? LAST : count - 1'b1;
         else      count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/line_serializer.sv
// Cache-line to memory-word serializer over a valid/ready stream.
// Define LINE_SER_CWF_EN for critical-word-first (start beat from in_start).
module line_serializer
   import serializer_pkg::*;
#(
   parameter int unsigned LINE_W     = DEF_LINE_W,
   parameter int unsigned WORD_W     = DEF_WORD_W,
   parameter bit          DESCENDING = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LINE_W-1:0]                  in_line,
   input  logic [$clog2(LINE_W/WORD_W)-1:0]   in_start,
   input  logic                               abort,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WORD_W-1:0]                  out_data,
   output logic [$clog2(LINE_W/WORD_W)-1:0]   out_idx,
   output logic                               out_last,
   output logic                               done
);
   localparam int unsigned BEATS = LINE_W / WORD_W;
   localparam int unsigned IDX_W = $clog2(BEATS);
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(BEATS - 1);

   ser_state_e        state, state_nxt;
   logic [LINE_W-1:0] line_reg;
   logic [IDX_W-1:0]  beat_idx, sent_cnt, start_idx;
   logic              load, beat_hs, final_hs;

`ifdef LINE_SER_CWF_EN
   assign start_idx = in_start;
`else
   logic unused_start;
   assign unused_start = ^in_start;
   assign start_idx    = DESCENDING ? LAST_CNT : '0;
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SEND;
         end
         SEND: begin
            out_valid = 1'b1;
            if (final_hs || abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load     = in_valid && in_ready;
   assign beat_hs  = out_valid && out_ready;
   assign final_hs = beat_hs && (sent_cnt == LAST_CNT);
   assign out_last = out_valid && (sent_cnt == LAST_CNT);
   assign out_idx  = beat_idx;
   assign out_data = line_reg[beat_idx*WORD_W +: WORD_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         line_reg <= '0;
         sent_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= final_hs;
         if (load) begin
            line_reg <= in_line;
            sent_cnt <= '0;
         end else if (beat_hs) begin
            // cleared on the last beat so the count never passes BEATS-1
            sent_cnt <= final_hs ? '0 : sent_cnt + 1'b1;
         end
      end
   end

   wrap_counter #(.N(BEATS), .DOWN(DESCENDING)) u_beat_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .en       (beat_hs),
      .load_val (start_idx),
      .count    (beat_idx)
   );
endmodule

// File: tb/tb_line_serializer.sv
// Randomized self-checking bench for line_serializer (default and 512/64 descending).
module tb_line_serializer;
   localparam int BA = 8, WA = 32, LA = 256;
   localparam int BB = 8, WB = 64, LB = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready, a_out_last, a_done;
   logic [LA-1:0] a_in_line;
   logic [2:0]    a_in_start, a_out_idx;
   logic [WA-1:0] a_out_data;

   logic          b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_out_last, b_done;
   logic [LB-1:0] b_in_line;
   logic [2:0]    b_in_start, b_out_idx;
   logic [WB-1:0] b_out_data;

   int checks = 0;
   int errors = 0;

   line_serializer dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_line(a_in_line), .in_start(a_in_start), .abort(a_abort),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_idx(a_out_idx), .out_last(a_out_last), .done(a_done)
   );

   line_serializer #(.LINE_W(LB), .WORD_W(WB), .DESCENDING(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_line(b_in_line), .in_start(b_in_start), .abort(b_abort),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_idx(b_out_idx), .out_last(b_out_last), .done(b_done)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // rmode: 0 always ready, 1 ready alternating starting low, 2 random.
   // abort_at: beat number at which abort is held for one cycle (-1 = never).
   task automatic run_a(input logic [LA-1:0] line, input logic [2:0] st,
                        input int rmode, input int abort_at);
      logic [WA-1:0] words[BA];
      int start, k, cyc, exp_idx;
      logic rdy, ab, finished;
      for (int i = 0; i < BA; i++) words[i] = line[i*WA +: WA];
`ifdef LINE_SER_CWF_EN
      start = int'(st);
`else
      start = 0;
`endif
      cyc = 0;
      while (!a_in_ready && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      check_eq("a_ready_before_load", a_in_ready, 1);
      a_in_valid = 1'b1; a_in_line = line; a_in_start = st;
      @(posedge clk); #1;
      a_in_line = {8{$urandom}}; a_in_start = 3'($urandom);
      check_eq("a_ready_busy", a_in_ready, 0);
      k = 0; cyc = 0; finished = 1'b0;
      while (!finished && cyc < 200) begin
         exp_idx = (start + k) % BA;
         check_eq("a_valid", a_out_valid, 1);
         check_eq("a_idx", a_out_idx, exp_idx);
         check_eq("a_data", a_out_data, words[exp_idx]);
         check_eq("a_last", a_out_last, k == BA - 1);
         check_eq("a_done_mid", a_done, 0);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2) == 1;
            default: rdy = ($urandom % 3) != 0;
         endcase
         ab = (k == abort_at);
         a_out_ready = rdy; a_abort = ab;
         a_in_valid = 1'(($urandom % 2));
         @(posedge clk); #1; cyc++;
         a_abort = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
         if (rdy) k++;
         if (k == BA || ab) finished = 1'b1;
      end
      if (!finished) check_eq("a_timeout", 0, 1);
      if (rmode == 0 && k == BA) check_eq("a_cycles_ready", cyc, BA);
      if (rmode == 1 && k == BA) check_eq("a_cycles_toggle", cyc, 2 * BA);
      check_eq("a_done_pulse", a_done, k == BA);
      check_eq("a_valid_after", a_out_valid, 0);
      check_eq("a_ready_after", a_in_ready, 1);
      @(posedge clk); #1;
      check_eq("a_done_single", a_done, 0);
   endtask

   task automatic run_b(input logic [LB-1:0] line, input logic [2:0] st);
      int start, k, exp_idx;
`ifdef LINE_SER_CWF_EN
      start = int'(st);
`else
      start = BB - 1;
`endif
      b_in_valid = 1'b1; b_in_line = line; b_in_start = st;
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_in_line = '0;
      b_out_ready = 1'b1;
      for (k = 0; k < BB; k++) begin
         exp_idx = (start - k + BB) % BB;
         check_eq("b_valid", b_out_valid, 1);
         check_eq("b_idx", b_out_idx, exp_idx);
         check_eq("b_data", b_out_data, line[exp_idx*WB +: WB]);
         check_eq("b_last", b_out_last, k == BB - 1);
         @(posedge clk); #1;
      end
      b_out_ready = 1'b0;
      check_eq("b_done", b_done, 1);
      check_eq("b_valid_after", b_out_valid, 0);
      @(posedge clk); #1;
      check_eq("b_done_single", b_done, 0);
   endtask

   initial begin
      logic [LA-1:0] la;
      logic [LB-1:0] lb;
      int ab_at;
      a_in_valid = 0; a_in_line = '0; a_in_start = '0; a_abort = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_line = '0; b_in_start = '0; b_abort = 0; b_out_ready = 0;
      #1;
      check_eq("rst_in_ready", a_in_ready, 1);
      check_eq("rst_out_valid", a_out_valid, 0);
      check_eq("rst_out_last", a_out_last, 0);
      check_eq("rst_out_idx", a_out_idx, 0);
      check_eq("rst_out_data", a_out_data, 0);
      check_eq("rst_done", a_done, 0);
      check_eq("rst_b_data", b_out_data, 0);
      #22 rst_n = 1'b1;
      @(posedge clk); #1;

      // abort while idle is ignored
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      check_eq("idle_abort_ready", a_in_ready, 1);
      check_eq("idle_abort_valid", a_out_valid, 0);

      for (int i = 0; i < BA; i++) la[i*WA +: WA] = 32'hA000_0000 + 32'(i);
      run_a(la, 3'd0, 0, -1);
      run_a(la, 3'd0, 1, -1);
      run_a(la, 3'd5, 0, -1);
      for (int i = 0; i < BA; i++) la[i*WA +: WA] = $urandom;
      run_a(la, 3'd0, 0, 3);
      run_a(la, 3'd2, 0, -1);
      run_a(la, 3'd0, 0, BA - 1);

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < BA; i++) la[i*WA +: WA] = $urandom;
         ab_at = ($urandom % 4 == 0) ? int'($urandom % BA) : -1;
         run_a(la, 3'($urandom), 2, ab_at);
      end

      // reset in the middle of a line
      for (int i = 0; i < BA; i++) la[i*WA +: WA] = $urandom;
      a_in_valid = 1'b1; a_in_line = la;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", a_out_valid, 0);
      check_eq("midrst_ready", a_in_ready, 1);
      check_eq("midrst_data", a_out_data, 0);
      check_eq("midrst_idx", a_out_idx, 0);
      check_eq("midrst_done", a_done, 0);
      #1 rst_n = 1'b1;
      a_out_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_done_after", a_done, 0);
      check_eq("midrst_valid_after", a_out_valid, 0);

      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < BB; i++) lb[i*WB +: WB] = {$urandom, $urandom};
         run_b(lb, 3'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
